// File: rtl/barrel_cmd_if.sv
// barrel_cmd_if: command-in and result-out handshake bundle for barrel_cmd_stage.
// Optional BARREL_CMD_PARITY_EN adds out_parity to the result side.
`default_nettype none

interface barrel_cmd_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_select;
    logic       in_control;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [2:0] out_select;
    logic       out_control;
`ifdef BARREL_CMD_PARITY_EN
    logic       out_parity;

    modport master (
        output in_valid, in_data, in_select, in_control, out_ready,
        input  in_ready, out_valid, out_result, out_select, out_control, out_parity
    );
    modport slave (
        input  in_valid, in_data, in_select, in_control, out_ready,
        output in_ready, out_valid, out_result, out_select, out_control, out_parity
    );
`else
    modport master (
        output in_valid, in_data, in_select, in_control, out_ready,
        input  in_ready, out_valid, out_result, out_select, out_control
    );
    modport slave (
        input  in_valid, in_data, in_select, in_control, out_ready,
        output in_ready, out_valid, out_result, out_select, out_control
    );
`endif
endinterface

`default_nettype wire

// File: rtl/barrel_cmd_stage.sv
// barrel_cmd_stage: command FIFO + settle sequencer in front of an 8-bit barrel shifter.
// Optional BARREL_CMD_PARITY_EN captures even parity of the result alongside it.
`default_nettype none

module barrel_cmd_stage #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    barrel_cmd_if.slave                   bus,
    output logic [7:0]                    sh_data,
    output logic [2:0]                    sh_select,
    output logic                          sh_control,
    input  wire logic [7:0]               sh_sor,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int C_AW = $clog2(DEPTH);
    localparam int C_CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [C_AW:0]   C_FULL       = (C_AW+1)'(DEPTH);
    localparam logic [C_CW-1:0] C_SETTLE_TOP = C_CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t          r_state;
    logic [C_CW-1:0] r_settle_cnt;
    logic [C_AW-1:0] r_wr_ptr;
    logic [C_AW-1:0] r_rd_ptr;
    logic [11:0]     r_mem [DEPTH];

    logic       r_out_valid;
    logic [7:0] r_out_result;
    logic [2:0] r_out_select;
    logic       r_out_control;

    logic        w_in_ready;
    logic        w_push;
    logic        w_pop;
    logic        w_fire_out;
    logic [11:0] w_head;

    assign w_in_ready = (count < C_FULL);
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_fire_out = r_out_valid && bus.out_ready;
    assign w_pop      = (count != '0) &&
                        ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && w_fire_out));
    assign w_head     = r_mem[r_rd_ptr];

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_result  = r_out_result;
    assign bus.out_select  = r_out_select;
    assign bus.out_control = r_out_control;

    // Storage carries no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_control, bus.in_select, bus.in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            count    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_settle_cnt  <= '0;
            sh_data       <= '0;
            sh_select     <= '0;
            sh_control    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_select  <= '0;
            r_out_control <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        {sh_control, sh_select, sh_data} <= w_head;
                        r_settle_cnt <= C_SETTLE_TOP;
                        r_state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_out_result  <= sh_sor;
                        r_out_select  <= sh_select;
                        r_out_control <= sh_control;
                        r_out_valid   <= 1'b1;
                        r_state       <= ST_HOLD;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (w_fire_out) begin
                        r_out_valid <= 1'b0;
                        // Back-to-back issue skips IDLE to sustain one result per SETTLE+1 cycles.
                        if (w_pop) begin
                            {sh_control, sh_select, sh_data} <= w_head;
                            r_settle_cnt <= C_SETTLE_TOP;
                            r_state      <= ST_SETTLE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef BARREL_CMD_PARITY_EN
    logic r_out_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_parity <= 1'b0;
        end else if ((r_state == ST_SETTLE) && (r_settle_cnt == '0)) begin
            r_out_parity <= ^sh_sor;
        end
    end

    assign bus.out_parity = r_out_parity;
`endif

endmodule

`default_nettype wire

// File: tb/tb_barrel_cmd_stage.sv
// tb_barrel_cmd_stage: randomized and directed checks of barrel_cmd_stage against a queue-based model.
`default_nettype none

module tb_barrel_cmd_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sh_data;
    logic [2:0] sh_select;
    logic       sh_control;
    logic [7:0] sh_sor;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] d;
        logic [2:0] s;
        logic       c;
    } cmd_t;

    cmd_t q[$];

    barrel_cmd_if bus();

    barrel_cmd_stage #(.DEPTH(4), .SETTLE(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .sh_data    (sh_data),
        .sh_select  (sh_select),
        .sh_control (sh_control),
        .sh_sor     (sh_sor),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Combinational shifter driven by the stage's registered outputs.
    logic [15:0] dbl;
    always_comb begin
        dbl    = {sh_data, sh_data} << sh_select;
        sh_sor = sh_control ? dbl[15:8] : (sh_data << sh_select);
    end

    // Reference result from plain arithmetic on the command.
    function automatic logic [7:0] ref_shift(cmd_t cm);
        int d = int'(cm.d);
        int s = int'(cm.s);
        int r = (d * (1 << s)) % 256;
        if (cm.c) r = r + d / (1 << (8 - s));
        return 8'(r);
    endfunction

    task automatic test_reset;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_select = '0;
        bus.in_control = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.out_valid, count} !== 4'b0) begin
            bad++; $display("FAIL rst_valid_count: got out_valid=%b count=%0d want 0/0", bus.out_valid, count);
        end
        total++;
        if ({sh_data, sh_select, sh_control} !== 12'h000) begin
            bad++; $display("FAIL rst_sh: got %h/%h/%b want 0", sh_data, sh_select, sh_control);
        end
        total++;
        if ({bus.out_result, bus.out_select, bus.out_control} !== 12'h000) begin
            bad++; $display("FAIL rst_out: got %h/%h/%b want 0", bus.out_result, bus.out_select, bus.out_control);
        end
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready_after: got %b want 1", bus.in_ready); end
    endtask

    // Single command from idle: checks latency, captured fields and release.
    task automatic run_single(input logic [7:0] d, input logic [2:0] s, input logic c,
                              input logic [7:0] exp_res, input string name);
        int waited = 0;
        @(negedge clk);
        bus.out_ready  = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = d;
        bus.in_select  = s;
        bus.in_control = c;
        while (!bus.in_ready && waited < 50) begin @(negedge clk); waited++; end
        if (!bus.in_ready) begin
            total++; bad++;
            $display("FAIL %s_accept: in_ready stuck low", name);
            bus.in_valid = 1'b0;
            return;
        end
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 0) bus.in_valid = 1'b0;
            total++;
            if (bus.out_valid !== (k == 3)) begin
                bad++; $display("FAIL %s_latency: cycle %0d out_valid=%b want %b", name, k, bus.out_valid, (k == 3));
            end
            if (k == 3) begin
                total++;
                if ({bus.out_result, bus.out_select, bus.out_control} !== {exp_res, s, c}) begin
                    bad++; $display("FAIL %s_result: got %h/%0d/%b want %h/%0d/%b", name,
                                    bus.out_result, bus.out_select, bus.out_control, exp_res, s, c);
                end
`ifdef BARREL_CMD_PARITY_EN
                total++;
                if (bus.out_parity !== ^exp_res) begin
                    bad++; $display("FAIL %s_parity: got %b want %b", name, bus.out_parity, ^exp_res);
                end
`endif
            end
        end
    endtask

    task automatic test_directed;
        run_single(8'h81, 3'd3, 1'b0, 8'h08, "lsl_81_3");
        run_single(8'h81, 3'd3, 1'b1, 8'h0C, "rol_81_3");
        run_single(8'hA5, 3'd0, 1'b1, 8'hA5, "rol_a5_0");
    endtask

    task automatic test_parity;
        run_single(8'h07, 3'd1, 1'b0, 8'h0E, "par_07_1");
        run_single(8'h03, 3'd2, 1'b1, 8'h0C, "par_03_2");
    endtask

    task automatic test_full_drain;
        int accepted = 0;
        int got = 0;
        int last = -1;
        int cyc = 0;
        cmd_t cm, e;
        q.delete();
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            cm.d = 8'($urandom); cm.s = 3'($urandom); cm.c = 1'($urandom);
            bus.in_valid = 1'b1; bus.in_data = cm.d; bus.in_select = cm.s; bus.in_control = cm.c;
            if (bus.in_ready) begin q.push_back(cm); accepted++; end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++;
        if (accepted !== 5) begin bad++; $display("FAIL full_accepted: got %0d want 5", accepted); end
        total++;
        if ({bus.in_ready, count} !== {1'b0, 3'd4}) begin
            bad++; $display("FAIL full_state: got in_ready=%b count=%0d want 0/4", bus.in_ready, count);
        end
        bus.out_ready = 1'b1;
        while (got < accepted && cyc < 100) begin
            if (bus.out_valid && bus.out_ready) begin
                e = q.pop_front();
                total++;
                if ({bus.out_result, bus.out_select, bus.out_control} !== {ref_shift(e), e.s, e.c}) begin
                    bad++; $display("FAIL drain_order: got %h/%0d/%b want %h/%0d/%b", bus.out_result,
                                    bus.out_select, bus.out_control, ref_shift(e), e.s, e.c);
                end
                if (last >= 0) begin
                    total++;
                    if (cyc - last !== 3) begin bad++; $display("FAIL drain_rate: got %0d cycles want 3", cyc - last); end
                end
                last = cyc;
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        total++;
        if (got !== accepted || count !== 3'd0) begin
            bad++; $display("FAIL drain_done: got %0d results count=%0d want %0d/0", got, count, accepted);
        end
    endtask

    task automatic test_backpressure;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic hold_prev = 1'b0;
        logic [11:0] saved = '0;
        cmd_t cm, e;
        q.delete();
        while (got < 100 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (hold_prev) begin
                total++;
                if ({bus.out_result, bus.out_select, bus.out_control} !== saved) begin
                    bad++; $display("FAIL bp_stable: got %h want %h",
                                    {bus.out_result, bus.out_select, bus.out_control}, saved);
                end
            end
            cm.d = 8'($urandom); cm.s = 3'($urandom); cm.c = 1'($urandom);
            bus.in_valid   = (sent < 100) && ($urandom_range(0, 3) != 0);
            bus.in_data    = cm.d; bus.in_select = cm.s; bus.in_control = cm.c;
            bus.out_ready  = 1'($urandom_range(0, 1));
            if (bus.in_valid && bus.in_ready) begin q.push_back(cm); sent++; end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL bp_extra: got %h want no result", bus.out_result);
                end else begin
                    e = q.pop_front();
                    if ({bus.out_result, bus.out_select, bus.out_control} !== {ref_shift(e), e.s, e.c}) begin
                        bad++; $display("FAIL bp_result: got %h/%0d/%b want %h/%0d/%b", bus.out_result,
                                        bus.out_select, bus.out_control, ref_shift(e), e.s, e.c);
                    end
`ifdef BARREL_CMD_PARITY_EN
                    if (bus.out_parity !== ^ref_shift(e)) begin
                        bad++; $display("FAIL bp_parity: got %b want %b", bus.out_parity, ^ref_shift(e));
                    end
`endif
                end
                got++;
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            saved = {bus.out_result, bus.out_select, bus.out_control};
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        total++;
        if (got !== 100 || q.size() != 0) begin
            bad++; $display("FAIL bp_count: got %0d results, %0d left want 100/0", got, q.size());
        end
    endtask

    task automatic test_reset_midflight;
        int waited = 0;
        @(negedge clk);
        bus.out_ready  = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'h5A;
        bus.in_select  = 3'd5;
        bus.in_control = 1'b1;
        while (!(count == 3'd3 && bus.out_valid) && waited < 50) begin @(negedge clk); waited++; end
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.out_valid, count} !== {1'b0, 3'd3}) begin
            bad++; $display("FAIL mid_setup: got out_valid=%b count=%0d want 0/3", bus.out_valid, count);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({count, bus.out_valid, bus.in_ready} !== {3'd0, 1'b0, 1'b1}) begin
            bad++; $display("FAIL mid_rst_state: got count=%0d out_valid=%b in_ready=%b want 0/0/1",
                            count, bus.out_valid, bus.in_ready);
        end
        total++;
        if ({sh_data, sh_select, sh_control} !== 12'h000) begin
            bad++; $display("FAIL mid_rst_sh: got %h/%h/%b want 0", sh_data, sh_select, sh_control);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_single(8'h01, 3'd7, 1'b0, 8'h80, "post_rst");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_parity();
        test_full_drain();
        test_backpressure();
        test_reset_midflight();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
